// File: rtl/reg_dump_unit.sv
// reg_dump_unit: once the core is halted, streams the register bank out over a
// valid/ready byte port. Each word is sent MSB byte first, and registers go out
// in ascending index order.
// Build option DUMP_PC_EN: when defined, pc_in is appended as one extra word
// after register NUM_REGS-1, so the stream is 4*NUM_REGS+4 bytes long.
// reg_dump_unit_chk holds the protocol assertions and is instantiated by the top.

module reg_dump_unit_chk (
  input logic       clk,
  input logic       reset,
  input logic       tx_valid,
  input logic       tx_ready,
  input logic [7:0] tx_data,
  input logic       busy,
  input logic       done,
  input logic [4:0] rf_rd_addr
);

  // A byte offered to the sink stays offered, unchanged, until it is taken.
  property p_stall_hold;
    @(posedge clk) disable iff (!reset)
      (tx_valid && !tx_ready) |=> (tx_valid && $stable(tx_data));
  endproperty
  a_stall_hold: assert property (p_stall_hold);

  // The completion pulse is a single cycle and never overlaps a live byte.
  property p_done_pulse;
    @(posedge clk) disable iff (!reset)
      done |-> (!tx_valid && !busy) ##1 !done;
  endproperty
  a_done_pulse: assert property (p_done_pulse);

  // The bank is only addressed while a dump is in progress.
  property p_addr_idle;
    @(posedge clk) disable iff (!reset)
      (rf_rd_addr != 5'd0) |-> busy;
  endproperty
  a_addr_idle: assert property (p_addr_idle);

endmodule

module reg_dump_unit #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic        start,
  output logic [4:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  input  logic [31:0] pc_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

`ifdef DUMP_PC_EN
  localparam int NUM_WORDS = NUM_REGS + 1;
`else
  localparam int NUM_WORDS = NUM_REGS;
`endif
  // Index of the final word of the stream (the PC word when it is enabled).
  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SEND    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t      state_r;
  logic [5:0]  word_idx_r;
  logic [1:0]  byte_cnt_r;
  logic [31:0] shift_r;
  logic [4:0]  rd_addr_r;
  logic        tx_valid_r;
  logic        busy_r;
  logic        done_r;

  logic        xfer_s;
  logic        word_end_s;
  logic        last_word_s;
  logic [5:0]  next_idx_s;
  logic [31:0] capture_word_s;

  // The outgoing byte is always the top byte of the shift register, so it is
  // registered by construction and needs no separate copy.
  assign tx_data    = shift_r[31:24];
  assign tx_valid   = tx_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign rf_rd_addr = rd_addr_r;

  // Decode handshake, end-of-word and end-of-stream conditions from state.
  always_comb begin
    xfer_s     = tx_valid_r & tx_ready;
    next_idx_s = word_idx_r + 6'd1;
    if (byte_cnt_r == 2'd3) begin
      word_end_s = 1'b1;
    end else begin
      word_end_s = 1'b0;
    end
    if (word_idx_r == LAST_IDX) begin
      last_word_s = 1'b1;
    end else begin
      last_word_s = 1'b0;
    end
  end

`ifdef DUMP_PC_EN
  // Choose the captured word: the bank read, or the PC for the trailing word.
  always_comb begin
    if (word_idx_r == LAST_IDX) begin
      capture_word_s = pc_in;
    end else begin
      capture_word_s = rf_rd_data;
    end
  end
`else
  // Without the PC word every captured word comes straight from the bank.
  always_comb begin
    capture_word_s = rf_rd_data;
  end

  // pc_in has no consumer in this build.
  logic pc_unused_s;
  assign pc_unused_s = ^pc_in;
`endif

  // Dump sequencer: FSM state, word/byte counters, shift register and all
  // registered outputs. done is raised on leaving DONE, so the pulse lands in
  // the cycle after the DONE state (cycle 2 + 5*words after the start edge).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      word_idx_r <= 6'd0;
      byte_cnt_r <= 2'd0;
      shift_r    <= 32'd0;
      rd_addr_r  <= 5'd0;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tx_valid_r <= 1'b0;
          rd_addr_r  <= 5'd0;
          if (start && halt) begin
            word_idx_r <= 6'd0;
            busy_r     <= 1'b1;
            state_r    <= ST_CAPTURE;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end

        ST_CAPTURE: begin
          shift_r    <= capture_word_s;
          byte_cnt_r <= 2'd0;
          tx_valid_r <= 1'b1;
          rd_addr_r  <= 5'd0;
          busy_r     <= 1'b1;
          state_r    <= ST_SEND;
        end

        ST_SEND: begin
          busy_r    <= 1'b1;
          rd_addr_r <= 5'd0;
          if (xfer_s) begin
            if (!word_end_s) begin
              shift_r    <= {shift_r[23:0], 8'd0};
              byte_cnt_r <= byte_cnt_r + 2'd1;
              tx_valid_r <= 1'b1;
              state_r    <= ST_SEND;
            end else if (last_word_s) begin
              tx_valid_r <= 1'b0;
              state_r    <= ST_DONE;
            end else begin
              // Present the next bank address so the read is ready in CAPTURE.
              tx_valid_r <= 1'b0;
              word_idx_r <= next_idx_s;
              rd_addr_r  <= next_idx_s[4:0];
              state_r    <= ST_CAPTURE;
            end
          end else begin
            tx_valid_r <= 1'b1;
            state_r    <= ST_SEND;
          end
        end

        ST_DONE: begin
          tx_valid_r <= 1'b0;
          rd_addr_r  <= 5'd0;
          busy_r     <= 1'b0;
          done_r     <= 1'b1;
          state_r    <= ST_IDLE;
        end

        default: begin
          tx_valid_r <= 1'b0;
          rd_addr_r  <= 5'd0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  reg_dump_unit_chk u_chk (
    .clk        (clk),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .busy       (busy),
    .done       (done),
    .rf_rd_addr (rf_rd_addr)
  );

endmodule

// File: tb/tb_reg_dump_unit.sv
// Bench for reg_dump_unit. The expected byte stream is built from the bank
// contents, one word after another, MSB byte first. A per-cycle compare step
// checks every transferred byte, stall stability and the done pulse.
// Cycle numbering: cycle 0 is the cycle in which start is sampled, and cycle n
// is the n-th cycle after that edge.
module tb_reg_dump_unit;
  localparam int NUM_REGS = 32;
`ifdef DUMP_PC_EN
  localparam int NUM_WORDS = NUM_REGS + 1;
`else
  localparam int NUM_WORDS = NUM_REGS;
`endif
  localparam int STREAM_LEN = 4 * NUM_WORDS;
  localparam int DONE_CYCLE = 2 + 5 * NUM_WORDS;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic        start;
  logic        tx_ready;
  logic [31:0] pc_in;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;
  logic [31:0] bank [0:NUM_REGS-1];

  assign rf_rd_data = bank[rf_rd_addr];

  always #5 clk = ~clk;

  reg_dump_unit #(.NUM_REGS(NUM_REGS)) dut (
    .clk        (clk),
    .reset      (reset),
    .halt       (halt),
    .start      (start),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .pc_in      (pc_in),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done)
  );

  int         total = 0;
  int         bad = 0;
  int         ncyc = 0;
  int         start_mark = 0;
  int         first_rel = -1;
  int         done_rel = -1;
  int         done_cnt = 0;
  bit         toggle = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [7:0] want_b;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name, input int got);
    total++;
    bad++;
    $display("FAIL %s: got %0d, bound exceeded", name, got);
  endtask

  // Per-cycle comparison against the stream model, sampled at the falling edge.
  task automatic compare_cycle();
    ncyc++;
    if (reset) begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, tx_valid}, 32'd1);
        check("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && first_rel < 0) first_rel = ncyc - start_mark;
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        if (exp_q.size() == 0) begin
          fail_now("extra_byte", got_q.size());
        end else begin
          want_b = exp_q.pop_front();
          check("stream_byte", {24'd0, tx_data}, {24'd0, want_b});
        end
      end
      if (done) begin
        done_cnt++;
        done_rel = ncyc - start_mark;
        check("done_no_valid", {31'd0, tx_valid}, 32'd0);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    if (toggle) tx_ready = ~tx_ready;
  endtask

  // Load the bank and rebuild the expected stream from it.
  task automatic load_bank(input bit rich);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rich) bank[i] = 32'hA5C3_0F1E ^ (32'(i) * 32'h0102_0305);
      else      bank[i] = 32'd0;
    end
    if (!rich) begin
      bank[1]  = 32'd5;
      bank[2]  = 32'd100;
      bank[5]  = 32'd153;
      bank[16] = 32'd24;
    end
    exp_q.delete();
    got_q.delete();
    first_rel = -1;
    done_rel  = -1;
    done_cnt  = 0;
    for (int i = 0; i < NUM_REGS; i++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(bank[i][8*b +: 8]);
`ifdef DUMP_PC_EN
    for (int b = 3; b >= 0; b--) exp_q.push_back(pc_in[8*b +: 8]);
`endif
  endtask

  task automatic start_dump();
    start = 1'b1;
    start_mark = ncyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == 0) fail_now(name, n);
    repeat (4) tick();
  endtask

  task automatic wait_bytes(input string name, input int count, input int budget);
    int n;
    n = 0;
    while (got_q.size() < count && n < budget) begin
      tick();
      n++;
    end
    if (got_q.size() < count) fail_now(name, got_q.size());
  endtask

  function automatic logic [31:0] word_at(input int i);
    return {got_q[i], got_q[i+1], got_q[i+2], got_q[i+3]};
  endfunction

  task automatic check_stream_end(input string name);
    check({name, "_len"}, got_q.size(), STREAM_LEN);
    check({name, "_left"}, exp_q.size(), 32'd0);
    check({name, "_done_cnt"}, done_cnt, 32'd1);
    check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; halt = 1'b1; start = 1'b0; tx_ready = 1'b1;
    pc_in = 32'h0000_0040;
    load_bank(1'b0);
    repeat (3) tick();
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_addr", {27'd0, rf_rd_addr}, 32'd0);
    reset = 1'b1;
    tick();

    // Preloaded bank, sink always ready.
    load_bank(1'b0);
    start_dump();
    check("a_busy_capture", {31'd0, busy}, 32'd1);
    check("a_valid_capture", {31'd0, tx_valid}, 32'd0);
    wait_done("a_done_timeout", 400);
    check_stream_end("a");
    check("a_first_valid_cycle", first_rel, 32'd2);
    check("a_done_cycle", done_rel, DONE_CYCLE);
    check("a_word0", word_at(0), 32'h0000_0000);
    check("a_bytes4_7", word_at(4), 32'h0000_0005);
    check("a_bytes8_11", word_at(8), 32'h0000_0064);
    check("a_bytes20_23", word_at(20), 32'h0000_0099);
    check("a_bytes64_67", word_at(64), 32'h0000_0018);
`ifdef DUMP_PC_EN
    check("a_pc_word", word_at(STREAM_LEN - 4), 32'h0000_0040);
`endif

    // Same bank, sink ready toggling every cycle.
    load_bank(1'b0);
    toggle = 1'b1;
    start_dump();
    wait_done("b_done_timeout", 800);
    toggle = 1'b0;
    tx_ready = 1'b1;
    check_stream_end("b");
    check("b_bytes20_23", word_at(20), 32'h0000_0099);

    // start while not halted must be ignored.
    halt = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("c_valid", {31'd0, tx_valid}, 32'd0);
      check("c_busy", {31'd0, busy}, 32'd0);
    end
    start = 1'b0;
    halt = 1'b1;
    tick();

    // Reset after byte 10 transfers, then a fresh full dump.
    load_bank(1'b1);
    start_dump();
    wait_bytes("d_bytes_timeout", 11, 100);
    reset = 1'b0;
    tick();
    check("d_valid_after_rst", {31'd0, tx_valid}, 32'd0);
    check("d_busy_after_rst", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    tick();
    load_bank(1'b0);
    start_dump();
    wait_done("d_done_timeout", 400);
    check_stream_end("d");
    check("d_byte0", {24'd0, got_q[0]}, 32'd0);
    check("d_done_cycle", done_rel, DONE_CYCLE);

    // start re-pulsed mid-dump has no effect; rich data pins byte order.
    load_bank(1'b1);
    start_dump();
    wait_bytes("e_bytes_timeout", 50, 100);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("e_done_timeout", 400);
    check_stream_end("e");
    check("e_word0", word_at(0), 32'hA5C3_0F1E);
    check("e_word1", word_at(4), 32'hA4C1_0C1B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
